// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control unit.
// Holds the FSM state encoding, the opcode/funct constants, the classified
// instruction type produced by ctrl_decode, every datapath mux-select
// encoding and the ALU operation codes.
package ctrl_pkg;

  typedef enum logic [5:0] {
    S_RESET,
    S_FETCH,
    S_MEM_WAIT,
    S_IR_LOAD,
    S_DECODE,
    S_EXEC_ADD,
    S_EXEC_SUB,
    S_EXEC_AND,
    S_WB_R,
    S_ADDI,
    S_WB_I,
    S_MEM_ADDR,
    S_LW_READ,
    S_LW_WAIT,
    S_LW_WB,
    S_SW_WRITE,
    S_BEQ,
    S_BNE,
    S_JUMP,
    S_JR,
    S_RTE,
    S_BREAK,
    S_EXC_OPC,
    S_EXC_OVF,
    S_EXC_OPC_RD,
    S_EXC_OPC_WAIT,
    S_EXC_OVF_RD,
    S_EXC_OVF_WAIT,
    S_EXC_JUMP
  } state_t;

  typedef enum logic [3:0] {
    INS_ADD,
    INS_SUB,
    INS_AND,
    INS_JR,
    INS_BREAK,
    INS_RTE,
    INS_ADDI,
    INS_LW,
    INS_SW,
    INS_BEQ,
    INS_BNE,
    INS_J,
    INS_ILLEGAL
  } instr_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_BREAK = 6'h0D;
  localparam logic [5:0] FN_RTE   = 6'h13;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;

  // ALU source A
  localparam logic [1:0] SRCA_PC = 2'd0;
  localparam logic [1:0] SRCA_A  = 2'd1;

  // ALU source B
  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  // ALU operation
  localparam logic [2:0] ALU_LOADA = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_CMP   = 3'b111;

  // Memory address source
  localparam logic [2:0] IORD_PC      = 3'd0;
  localparam logic [2:0] IORD_ALUOUT  = 3'd1;
  localparam logic [2:0] IORD_EXC_OPC = 3'd3;
  localparam logic [2:0] IORD_EXC_OVF = 3'd4;

  // PC source
  localparam logic [2:0] PCSRC_ALU    = 3'd0;
  localparam logic [2:0] PCSRC_ALUOUT = 3'd1;
  localparam logic [2:0] PCSRC_JUMP   = 3'd2;
  localparam logic [2:0] PCSRC_EPC    = 3'd3;
  localparam logic [2:0] PCSRC_MDR    = 3'd4;

  // Register file write address
  localparam logic [2:0] REGDST_RT = 3'd0;
  localparam logic [2:0] REGDST_RD = 3'd1;
  localparam logic [2:0] REGDST_SP = 3'd2;

  // Register file write data
  localparam logic [3:0] MEMTOREG_ALUOUT = 4'd0;
  localparam logic [3:0] MEMTOREG_MDR    = 4'd1;
  localparam logic [3:0] MEMTOREG_SPINIT = 4'd2;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode/funct classifier for the control unit.
// Ports:
//   i_opcode - IR[31:26]
//   i_funct  - IR[5:0]
//   o_instr  - instruction class; INS_ILLEGAL for any unsupported
//              opcode or R-type funct
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output instr_t     o_instr
);

  always_comb begin
    o_instr = INS_ILLEGAL;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADD:   o_instr = INS_ADD;
          FN_SUB:   o_instr = INS_SUB;
          FN_AND:   o_instr = INS_AND;
          FN_JR:    o_instr = INS_JR;
          FN_BREAK: o_instr = INS_BREAK;
          FN_RTE:   o_instr = INS_RTE;
          default:  o_instr = INS_ILLEGAL;
        endcase
      end
      OP_ADDI: o_instr = INS_ADDI;
      OP_LW:   o_instr = INS_LW;
      OP_SW:   o_instr = INS_SW;
      OP_BEQ:  o_instr = INS_BEQ;
      OP_BNE:  o_instr = INS_BNE;
      OP_J:    o_instr = INS_J;
      default: o_instr = INS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/ctrl_unit.sv
// Multicycle control unit FSM.
// Ports:
//   clk, reset          - clock; synchronous active-high reset
//   opcode, funct       - instruction fields IR[31:26], IR[5:0]
//   Of,Zr,Eq,Gt,Lt,Ng   - ALU flags (Of and Eq are consumed)
//   PC_w .. EPCWrite    - register/memory write strobes
//   CtrlALUSrcA/B, CtrlULA, CtrlIord, CtrlPCSource, CtrlRegDst,
//   CtrlMemtoReg        - datapath mux selects and ALU operation
//   state_o             - current state, for debug
module ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int SP_INIT      = 227,
  parameter int EXC_OPC_ADDR = 253,
  parameter int EXC_OVF_ADDR = 254
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Of,
  input  logic       Zr,
  input  logic       Eq,
  input  logic       Gt,
  input  logic       Lt,
  input  logic       Ng,
  output logic       PC_w,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MDRWrite,
  output logic       RegWrite,
  output logic       ABWrite,
  output logic       ALUoutWrite,
  output logic       EPCWrite,
  output logic [1:0] CtrlALUSrcA,
  output logic [1:0] CtrlALUSrcB,
  output logic [2:0] CtrlULA,
  output logic [2:0] CtrlIord,
  output logic [2:0] CtrlPCSource,
  output logic [2:0] CtrlRegDst,
  output logic [3:0] CtrlMemtoReg,
  output logic [5:0] state_o
);

  // The datapath owns these values; the controller only selects them.
  if (SP_INIT < 0 || EXC_OPC_ADDR < 0 || EXC_OPC_ADDR > 255 ||
      EXC_OVF_ADDR < 0 || EXC_OVF_ADDR > 255 ||
      EXC_OPC_ADDR == EXC_OVF_ADDR) begin : g_bad_param
    $error("ctrl_unit: invalid SP_INIT or exception handler addresses");
  end

  state_t r_state;
  state_t w_next;
  instr_t w_instr;
  logic   w_unused_flags;

  assign w_unused_flags = ^{Zr, Gt, Lt, Ng};
  assign state_o        = r_state;

  ctrl_decode u_decode (
    .i_opcode (opcode),
    .i_funct  (funct),
    .o_instr  (w_instr)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RESET;
    else       r_state <= w_next;
  end

  // EXEC and BRANCH are split per operation so that the ALU op and the
  // branch sense are functions of state alone.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET:    w_next = S_FETCH;
      S_FETCH:    w_next = S_MEM_WAIT;
      S_MEM_WAIT: w_next = S_IR_LOAD;
      S_IR_LOAD:  w_next = S_DECODE;
      S_DECODE: begin
        case (w_instr)
          INS_ADD:   w_next = S_EXEC_ADD;
          INS_SUB:   w_next = S_EXEC_SUB;
          INS_AND:   w_next = S_EXEC_AND;
          INS_JR:    w_next = S_JR;
          INS_BREAK: w_next = S_BREAK;
          INS_RTE:   w_next = S_RTE;
          INS_ADDI:  w_next = S_ADDI;
          INS_LW:    w_next = S_MEM_ADDR;
          INS_SW:    w_next = S_MEM_ADDR;
          INS_BEQ:   w_next = S_BEQ;
          INS_BNE:   w_next = S_BNE;
          INS_J:     w_next = S_JUMP;
          default:   w_next = S_EXC_OPC;
        endcase
      end
      S_EXEC_ADD,
      S_EXEC_SUB:     w_next = Of ? S_EXC_OVF : S_WB_R;
      S_EXEC_AND:     w_next = S_WB_R;
      S_ADDI:         w_next = Of ? S_EXC_OVF : S_WB_I;
      S_MEM_ADDR:     w_next = (w_instr == INS_LW) ? S_LW_READ : S_SW_WRITE;
      S_LW_READ:      w_next = S_LW_WAIT;
      S_LW_WAIT:      w_next = S_LW_WB;
      S_EXC_OPC:      w_next = S_EXC_OPC_RD;
      S_EXC_OPC_RD:   w_next = S_EXC_OPC_WAIT;
      S_EXC_OPC_WAIT: w_next = S_EXC_JUMP;
      S_EXC_OVF:      w_next = S_EXC_OVF_RD;
      S_EXC_OVF_RD:   w_next = S_EXC_OVF_WAIT;
      S_EXC_OVF_WAIT: w_next = S_EXC_JUMP;
      default:        w_next = S_FETCH;
    endcase
  end

  always_comb begin
    PC_w         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    MDRWrite     = 1'b0;
    RegWrite     = 1'b0;
    ABWrite      = 1'b0;
    ALUoutWrite  = 1'b0;
    EPCWrite     = 1'b0;
    CtrlALUSrcA  = SRCA_PC;
    CtrlALUSrcB  = SRCB_B;
    CtrlULA      = ALU_LOADA;
    CtrlIord     = IORD_PC;
    CtrlPCSource = PCSRC_ALU;
    CtrlRegDst   = REGDST_RT;
    CtrlMemtoReg = MEMTOREG_ALUOUT;
    case (r_state)
      S_RESET: begin
        RegWrite     = 1'b1;
        CtrlRegDst   = REGDST_SP;
        CtrlMemtoReg = MEMTOREG_SPINIT;
      end
      S_FETCH: begin
        MemRead     = 1'b1;
        PC_w        = 1'b1;
        CtrlALUSrcB = SRCB_FOUR;
        CtrlULA     = ALU_ADD;
      end
      S_MEM_WAIT: MemRead = 1'b1;
      S_IR_LOAD:  IRWrite = 1'b1;
      S_DECODE: begin
        ABWrite     = 1'b1;
        ALUoutWrite = 1'b1;
        CtrlALUSrcB = SRCB_IMM_SH2;
        CtrlULA     = ALU_ADD;
      end
      S_EXEC_ADD, S_EXEC_SUB, S_EXEC_AND: begin
        ALUoutWrite = 1'b1;
        CtrlALUSrcA = SRCA_A;
        CtrlALUSrcB = SRCB_B;
        CtrlULA     = (r_state == S_EXEC_ADD) ? ALU_ADD :
                      (r_state == S_EXEC_SUB) ? ALU_SUB : ALU_AND;
      end
      S_WB_R: begin
        RegWrite   = 1'b1;
        CtrlRegDst = REGDST_RD;
      end
      S_ADDI, S_MEM_ADDR: begin
        ALUoutWrite = 1'b1;
        CtrlALUSrcA = SRCA_A;
        CtrlALUSrcB = SRCB_IMM;
        CtrlULA     = ALU_ADD;
      end
      S_WB_I: RegWrite = 1'b1;
      S_LW_READ: begin
        MemRead  = 1'b1;
        CtrlIord = IORD_ALUOUT;
      end
      S_LW_WAIT: begin
        MemRead  = 1'b1;
        MDRWrite = 1'b1;
        CtrlIord = IORD_ALUOUT;
      end
      S_LW_WB: begin
        RegWrite     = 1'b1;
        CtrlMemtoReg = MEMTOREG_MDR;
      end
      S_SW_WRITE: begin
        MemWrite = 1'b1;
        CtrlIord = IORD_ALUOUT;
      end
      S_BEQ, S_BNE: begin
        PC_w         = (r_state == S_BEQ) ? Eq : !Eq;
        CtrlALUSrcA  = SRCA_A;
        CtrlULA      = ALU_CMP;
        CtrlPCSource = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        PC_w         = 1'b1;
        CtrlPCSource = PCSRC_JUMP;
      end
      S_JR: begin
        PC_w         = 1'b1;
        CtrlALUSrcA  = SRCA_A;
        CtrlULA      = ALU_LOADA;
        CtrlPCSource = PCSRC_ALU;
      end
      S_RTE: begin
        PC_w         = 1'b1;
        CtrlPCSource = PCSRC_EPC;
      end
      // PC already points past the break; PC-4 makes it re-execute.
      S_BREAK: begin
        PC_w         = 1'b1;
        CtrlALUSrcB  = SRCB_FOUR;
        CtrlULA      = ALU_SUB;
        CtrlPCSource = PCSRC_ALU;
      end
      S_EXC_OPC, S_EXC_OVF: begin
        EPCWrite    = 1'b1;
        CtrlALUSrcB = SRCB_FOUR;
        CtrlULA     = ALU_SUB;
      end
      S_EXC_OPC_RD: begin
        MemRead  = 1'b1;
        CtrlIord = IORD_EXC_OPC;
      end
      S_EXC_OPC_WAIT: begin
        MemRead  = 1'b1;
        MDRWrite = 1'b1;
        CtrlIord = IORD_EXC_OPC;
      end
      S_EXC_OVF_RD: begin
        MemRead  = 1'b1;
        CtrlIord = IORD_EXC_OVF;
      end
      S_EXC_OVF_WAIT: begin
        MemRead  = 1'b1;
        MDRWrite = 1'b1;
        CtrlIord = IORD_EXC_OVF;
      end
      S_EXC_JUMP: begin
        PC_w         = 1'b1;
        CtrlPCSource = PCSRC_MDR;
      end
      default: ;
    endcase
    // Reset gates every output immediately, so the cycle in which reset is
    // raised mid-instruction performs no writes.
    if (reset) begin
      PC_w         = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      MDRWrite     = 1'b0;
      RegWrite     = 1'b0;
      ABWrite      = 1'b0;
      ALUoutWrite  = 1'b0;
      EPCWrite     = 1'b0;
      CtrlALUSrcA  = '0;
      CtrlALUSrcB  = '0;
      CtrlULA      = '0;
      CtrlIord     = '0;
      CtrlPCSource = '0;
      CtrlRegDst   = '0;
      CtrlMemtoReg = '0;
    end
  end

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed self-checking bench for ctrl_unit.
module tb_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       Of = 1'b0, Zr = 1'b0, Eq = 1'b0, Gt = 1'b0, Lt = 1'b0, Ng = 1'b0;
  logic       PC_w, MemRead, MemWrite, IRWrite, MDRWrite, RegWrite;
  logic       ABWrite, ALUoutWrite, EPCWrite;
  logic [1:0] CtrlALUSrcA, CtrlALUSrcB;
  logic [2:0] CtrlULA, CtrlIord, CtrlPCSource, CtrlRegDst;
  logic [3:0] CtrlMemtoReg;
  logic [5:0] state_o;

  int checks = 0;
  int errors = 0;

  // Strobe vector bit positions: {PC_w,MemRead,MemWrite,IRWrite,MDRWrite,
  //                               RegWrite,ABWrite,ALUoutWrite,EPCWrite}
  localparam logic [8:0] PCW = 9'h100;
  localparam logic [8:0] MR  = 9'h080;
  localparam logic [8:0] MW  = 9'h040;
  localparam logic [8:0] IRW = 9'h020;
  localparam logic [8:0] MDR = 9'h010;
  localparam logic [8:0] RW  = 9'h008;
  localparam logic [8:0] AB  = 9'h004;
  localparam logic [8:0] ALO = 9'h002;
  localparam logic [8:0] EPC = 9'h001;
  localparam logic [8:0] NONE = 9'h000;

  ctrl_unit #(.SP_INIT(227), .EXC_OPC_ADDR(253), .EXC_OVF_ADDR(254)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .funct        (funct),
    .Of           (Of),
    .Zr           (Zr),
    .Eq           (Eq),
    .Gt           (Gt),
    .Lt           (Lt),
    .Ng           (Ng),
    .PC_w         (PC_w),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .IRWrite      (IRWrite),
    .MDRWrite     (MDRWrite),
    .RegWrite     (RegWrite),
    .ABWrite      (ABWrite),
    .ALUoutWrite  (ALUoutWrite),
    .EPCWrite     (EPCWrite),
    .CtrlALUSrcA  (CtrlALUSrcA),
    .CtrlALUSrcB  (CtrlALUSrcB),
    .CtrlULA      (CtrlULA),
    .CtrlIord     (CtrlIord),
    .CtrlPCSource (CtrlPCSource),
    .CtrlRegDst   (CtrlRegDst),
    .CtrlMemtoReg (CtrlMemtoReg),
    .state_o      (state_o)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [8:0] strb();
    return {PC_w, MemRead, MemWrite, IRWrite, MDRWrite, RegWrite,
            ABWrite, ALUoutWrite, EPCWrite};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  // Cycles 1-4: FETCH, MEM_WAIT, IR_LOAD, DECODE.
  task automatic front(input string t);
    nxt();
    chk({t, " c1 strobes"}, 32'(strb()), 32'(PCW | MR));
    chk({t, " c1 srcB"}, 32'(CtrlALUSrcB), 32'd1);
    chk({t, " c1 ulA"}, 32'(CtrlULA), 32'd1);
    nxt();
    chk({t, " c2 strobes"}, 32'(strb()), 32'(MR));
    nxt();
    chk({t, " c3 strobes"}, 32'(strb()), 32'(IRW));
    nxt();
    chk({t, " c4 strobes"}, 32'(strb()), 32'(AB | ALO));
    chk({t, " c4 srcB"}, 32'(CtrlALUSrcB), 32'd3);
  endtask

  initial begin
    // Reset held for three cycles
    repeat (3) begin
      nxt();
      chk("reset strobes", 32'(strb()), 32'(NONE));
    end
    reset = 1'b0;
    #1;
    chk("post-reset strobes", 32'(strb()), 32'(RW));
    chk("post-reset regdst", 32'(CtrlRegDst), 32'd2);
    chk("post-reset memtoreg", 32'(CtrlMemtoReg), 32'd2);

    // add, no overflow
    opcode = 6'h00; funct = 6'h20; Of = 1'b0;
    front("add");
    nxt();
    chk("add c5 strobes", 32'(strb()), 32'(ALO));
    chk("add c5 srcA", 32'(CtrlALUSrcA), 32'd1);
    chk("add c5 srcB", 32'(CtrlALUSrcB), 32'd0);
    chk("add c5 ulA", 32'(CtrlULA), 32'd1);
    nxt();
    chk("add c6 strobes", 32'(strb()), 32'(RW));
    chk("add c6 regdst", 32'(CtrlRegDst), 32'd1);
    chk("add c6 memtoreg", 32'(CtrlMemtoReg), 32'd0);

    // add with overflow
    Of = 1'b1;
    front("addovf");
    nxt();
    chk("addovf c5 strobes", 32'(strb()), 32'(ALO));
    nxt();
    chk("addovf c6 strobes", 32'(strb()), 32'(EPC));
    chk("addovf c6 ulA", 32'(CtrlULA), 32'd2);
    chk("addovf c6 srcB", 32'(CtrlALUSrcB), 32'd1);
    nxt();
    chk("addovf c7 strobes", 32'(strb()), 32'(MR));
    chk("addovf c7 iord", 32'(CtrlIord), 32'd4);
    nxt();
    chk("addovf c8 strobes", 32'(strb()), 32'(MR | MDR));
    chk("addovf c8 iord", 32'(CtrlIord), 32'd4);
    nxt();
    chk("addovf c9 strobes", 32'(strb()), 32'(PCW));
    chk("addovf c9 pcsrc", 32'(CtrlPCSource), 32'd4);

    // and ignores Of
    funct = 6'h24;
    front("and");
    nxt();
    chk("and c5 ulA", 32'(CtrlULA), 32'd3);
    nxt();
    chk("and c6 strobes", 32'(strb()), 32'(RW));

    // sub, no overflow
    funct = 6'h22; Of = 1'b0;
    front("sub");
    nxt();
    chk("sub c5 ulA", 32'(CtrlULA), 32'd2);
    nxt();
    chk("sub c6 strobes", 32'(strb()), 32'(RW));
    chk("sub c6 regdst", 32'(CtrlRegDst), 32'd1);

    // addi with overflow, then without
    opcode = 6'h08; Of = 1'b1;
    front("addiovf");
    nxt();
    chk("addiovf c5 strobes", 32'(strb()), 32'(ALO));
    chk("addiovf c5 srcB", 32'(CtrlALUSrcB), 32'd2);
    nxt();
    chk("addiovf c6 strobes", 32'(strb()), 32'(EPC));
    nxt();
    nxt();
    nxt();
    chk("addiovf c9 strobes", 32'(strb()), 32'(PCW));
    Of = 1'b0;
    front("addi");
    nxt();
    nxt();
    chk("addi c6 strobes", 32'(strb()), 32'(RW));
    chk("addi c6 regdst", 32'(CtrlRegDst), 32'd0);

    // beq taken, then flag drop within the same cycle
    opcode = 6'h04; Eq = 1'b1;
    front("beq");
    nxt();
    chk("beq c5 strobes", 32'(strb()), 32'(PCW));
    chk("beq c5 pcsrc", 32'(CtrlPCSource), 32'd1);
    chk("beq c5 ulA", 32'(CtrlULA), 32'd7);
    Eq = 1'b0;
    #1;
    chk("beq c5 noteq pcw", 32'(PC_w), 32'd0);

    // bne with Eq=1 not taken, Eq=0 taken
    opcode = 6'h05; Eq = 1'b1;
    front("bne");
    nxt();
    chk("bne c5 strobes", 32'(strb()), 32'(NONE));
    Eq = 1'b0;
    #1;
    chk("bne c5 noteq pcw", 32'(PC_w), 32'd1);

    // lw
    opcode = 6'h23;
    front("lw");
    nxt();
    chk("lw c5 strobes", 32'(strb()), 32'(ALO));
    nxt();
    chk("lw c6 strobes", 32'(strb()), 32'(MR));
    chk("lw c6 iord", 32'(CtrlIord), 32'd1);
    nxt();
    chk("lw c7 strobes", 32'(strb()), 32'(MR | MDR));
    chk("lw c7 iord", 32'(CtrlIord), 32'd1);
    nxt();
    chk("lw c8 strobes", 32'(strb()), 32'(RW));
    chk("lw c8 memtoreg", 32'(CtrlMemtoReg), 32'd1);
    chk("lw c8 regdst", 32'(CtrlRegDst), 32'd0);

    // sw
    opcode = 6'h2B;
    front("sw");
    nxt();
    chk("sw c5 strobes", 32'(strb()), 32'(ALO));
    nxt();
    chk("sw c6 strobes", 32'(strb()), 32'(MW));
    chk("sw c6 iord", 32'(CtrlIord), 32'd1);

    // j
    opcode = 6'h02;
    front("j");
    nxt();
    chk("j c5 strobes", 32'(strb()), 32'(PCW));
    chk("j c5 pcsrc", 32'(CtrlPCSource), 32'd2);

    // jr
    opcode = 6'h00; funct = 6'h08;
    front("jr");
    nxt();
    chk("jr c5 strobes", 32'(strb()), 32'(PCW));
    chk("jr c5 srcA", 32'(CtrlALUSrcA), 32'd1);
    chk("jr c5 ulA", 32'(CtrlULA), 32'd0);
    chk("jr c5 pcsrc", 32'(CtrlPCSource), 32'd0);

    // rte
    funct = 6'h13;
    front("rte");
    nxt();
    chk("rte c5 strobes", 32'(strb()), 32'(PCW));
    chk("rte c5 pcsrc", 32'(CtrlPCSource), 32'd3);

    // break
    funct = 6'h0D;
    front("break");
    nxt();
    chk("break c5 strobes", 32'(strb()), 32'(PCW));
    chk("break c5 ulA", 32'(CtrlULA), 32'd2);
    chk("break c5 srcB", 32'(CtrlALUSrcB), 32'd1);
    chk("break c5 pcsrc", 32'(CtrlPCSource), 32'd0);

    // illegal opcode
    opcode = 6'h3F;
    front("badop");
    nxt();
    chk("badop c5 strobes", 32'(strb()), 32'(EPC));
    nxt();
    chk("badop c6 strobes", 32'(strb()), 32'(MR));
    chk("badop c6 iord", 32'(CtrlIord), 32'd3);
    nxt();
    chk("badop c7 strobes", 32'(strb()), 32'(MR | MDR));
    chk("badop c7 iord", 32'(CtrlIord), 32'd3);
    nxt();
    chk("badop c8 strobes", 32'(strb()), 32'(PCW));
    chk("badop c8 pcsrc", 32'(CtrlPCSource), 32'd4);

    // illegal R-type funct (front() also checks FETCH follows EXC_JUMP)
    opcode = 6'h00; funct = 6'h21;
    front("badfn");
    nxt();
    chk("badfn c5 strobes", 32'(strb()), 32'(EPC));
    nxt();
    chk("badfn c6 iord", 32'(CtrlIord), 32'd3);
    nxt();
    nxt();
    chk("badfn c8 pcsrc", 32'(CtrlPCSource), 32'd4);

    // reset during LW_WAIT
    opcode = 6'h23;
    front("lwrst");
    nxt();
    nxt();
    nxt();
    chk("lwrst c7 strobes", 32'(strb()), 32'(MR | MDR));
    reset = 1'b1;
    #1;
    chk("lwrst abort strobes", 32'(strb()), 32'(NONE));
    nxt();
    chk("lwrst held strobes", 32'(strb()), 32'(NONE));
    reset = 1'b0;
    #1;
    chk("lwrst release strobes", 32'(strb()), 32'(RW));
    chk("lwrst release regdst", 32'(CtrlRegDst), 32'd2);
    chk("lwrst release memtoreg", 32'(CtrlMemtoReg), 32'd2);
    nxt();
    chk("lwrst fetch strobes", 32'(strb()), 32'(PCW | MR));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
